// File: rtl/pcie_mwr_tlp_framer.sv
// PCIe MWr32 TLP framer: splits a configured transfer into TLPs of at most
// MAX_PAYLOAD_DW dwords, prepends a 3DW header and shifts payload by one dword.
module pcie_mwr_tlp_framer #(
    parameter int MAX_PAYLOAD_DW = 32
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        CFG_START,
    input  logic [31:0] CFG_ADDR,
    input  logic [23:0] CFG_DW_COUNT,
    input  logic [15:0] CFG_REQ_ID,
    output logic        BUSY,
    output logic        DONE,
    input  logic        S00_AXIS_TVALID,
    output logic        S00_AXIS_TREADY,
    input  logic [63:0] S00_AXIS_TDATA,
    input  logic [7:0]  S00_AXIS_TKEEP,
    input  logic        S00_AXIS_TLAST,
    output logic        M00_AXIS_TVALID,
    input  logic        M00_AXIS_TREADY,
    output logic [63:0] M00_AXIS_TDATA,
    output logic [7:0]  M00_AXIS_TKEEP,
    output logic        M00_AXIS_TLAST
);

    localparam logic [23:0] MAX_REM = 24'(MAX_PAYLOAD_DW);
    localparam logic [10:0] MAX_LEN = 11'(MAX_PAYLOAD_DW);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_H2D  = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [23:0] rem_q, rem_d;
    logic [15:0] req_id_q, req_id_d;
    logic [7:0]  tag_q, tag_d;
    logic [31:0] hold_q, hold_d;
    logic [10:0] len_q, len_d;
    logic [9:0]  beat_q, beat_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [10:0] cur_len_s;
    logic [9:0]  last_idx_s;
    logic        is_last_s;
    logic        in_hs_s;
    logic        tlp_end_s;
    logic [31:0] h0_s, h1_s, h2_s;
    logic        m_tvalid_s, s_tready_s, m_tlast_s;
    logic [63:0] m_tdata_s;
    logic [7:0]  m_tkeep_s;
    logic        unused_s;

    assign unused_s   = ^{S00_AXIS_TKEEP, S00_AXIS_TLAST, CFG_ADDR[1:0]};

    // Length of the TLP about to start; remaining count is only debited at its header.
    assign cur_len_s  = (rem_q > MAX_REM) ? MAX_LEN : rem_q[10:0];
    assign last_idx_s = len_q[10:1] + 10'd1;
    assign is_last_s  = (beat_q == last_idx_s);
    assign in_hs_s    = S00_AXIS_TVALID && M00_AXIS_TREADY;

    assign h0_s = {1'b0, 2'b10, 5'b00000, 14'b0, cur_len_s[9:0]};
    assign h1_s = {req_id_q, tag_q, ((cur_len_s > 11'd1) ? 4'hF : 4'h0), 4'hF};
    assign h2_s = {addr_q, 2'b00};

    // Next-state, datapath muxing and handshake steering.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        req_id_d   = req_id_q;
        tag_d      = tag_q;
        hold_d     = hold_q;
        len_d      = len_q;
        beat_d     = beat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tlp_end_s  = 1'b0;
        m_tvalid_s = 1'b0;
        s_tready_s = 1'b0;
        m_tdata_s  = 64'h0;
        m_tkeep_s  = 8'h00;
        m_tlast_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (CFG_START && (CFG_DW_COUNT != 24'd0)) begin
                    addr_d   = CFG_ADDR[31:2];
                    rem_d    = CFG_DW_COUNT;
                    req_id_d = CFG_REQ_ID;
                    busy_d   = 1'b1;
                    state_d  = ST_HDR;
                end else if (CFG_START) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                m_tvalid_s = 1'b1;
                m_tdata_s  = {h1_s, h0_s};
                m_tkeep_s  = 8'hFF;
                if (M00_AXIS_TREADY) begin
                    len_d   = cur_len_s;
                    rem_d   = rem_q - {13'd0, cur_len_s};
                    beat_d  = 10'd1;
                    state_d = ST_H2D;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_H2D: begin
                m_tvalid_s = S00_AXIS_TVALID;
                s_tready_s = M00_AXIS_TREADY;
                m_tdata_s  = {S00_AXIS_TDATA[31:0], h2_s};
                m_tkeep_s  = 8'hFF;
                m_tlast_s  = is_last_s;
                if (in_hs_s) begin
                    hold_d    = S00_AXIS_TDATA[63:32];
                    beat_d    = beat_q + 10'd1;
                    tlp_end_s = is_last_s;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_H2D;
                end
            end
            ST_DATA: begin
                // An even-length TLP ends on a beat carrying only the held dword.
                if (is_last_s && !len_q[0]) begin
                    m_tvalid_s = 1'b1;
                    m_tdata_s  = {32'h0, hold_q};
                    m_tkeep_s  = 8'h0F;
                    m_tlast_s  = 1'b1;
                    tlp_end_s  = M00_AXIS_TREADY;
                end else begin
                    m_tvalid_s = S00_AXIS_TVALID;
                    s_tready_s = M00_AXIS_TREADY;
                    m_tdata_s  = {S00_AXIS_TDATA[31:0], hold_q};
                    m_tkeep_s  = 8'hFF;
                    m_tlast_s  = is_last_s;
                    if (in_hs_s) begin
                        hold_d    = S00_AXIS_TDATA[63:32];
                        beat_d    = beat_q + 10'd1;
                        tlp_end_s = is_last_s;
                    end else begin
                        tlp_end_s = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (tlp_end_s) begin
            addr_d = addr_q + {19'd0, len_q};
            tag_d  = tag_q + 8'd1;
            if (rem_q != 24'd0) begin
                state_d = ST_HDR;
            end else begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
        end else begin
            tag_d = tag_d;
        end
    end

    // State and context registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= ST_IDLE;
            addr_q   <= 30'd0;
            rem_q    <= 24'd0;
            req_id_q <= 16'd0;
            tag_q    <= 8'd0;
            hold_q   <= 32'd0;
            len_q    <= 11'd0;
            beat_q   <= 10'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            req_id_q <= req_id_d;
            tag_q    <= tag_d;
            hold_q   <= hold_d;
            len_q    <= len_d;
            beat_q   <= beat_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign BUSY            = busy_q;
    assign DONE            = done_q;
    assign S00_AXIS_TREADY = s_tready_s;
    assign M00_AXIS_TVALID = m_tvalid_s;
    assign M00_AXIS_TDATA  = m_tdata_s;
    assign M00_AXIS_TKEEP  = m_tkeep_s;
    assign M00_AXIS_TLAST  = m_tlast_s;

endmodule

// File: tb/tb_pcie_mwr_tlp_framer.sv
// Bench for pcie_mwr_tlp_framer: table of transfers plus random transfers,
// each checked against a dword-stream model of the TLP format.
module tb_pcie_mwr_tlp_framer;

    localparam int MAXP = 32;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [31:0] cfg_addr = 32'h0;
    logic [23:0] cfg_dw_count = 24'h0;
    logic [15:0] cfg_req_id = 16'h0;
    logic        busy, done;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] s_tdata = 64'h0;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;

    int checks = 0;
    int errors = 0;

    logic [63:0] in_beats[$];
    logic [63:0] exp_data[$];
    logic [8:0]  exp_kl[$];
    logic [7:0]  tag_m = 8'd0;
    logic [63:0] first_beat;

    typedef struct {
        logic [31:0] addr;
        int          count;
        logic [15:0] rid;
        bit          thr;
        bit          poke;
        int          beats;
        int          ins;
    } vec_t;

    vec_t tbl[8];

    pcie_mwr_tlp_framer #(.MAX_PAYLOAD_DW(MAXP)) dut (
        .ACLK(aclk), .ARESETN(aresetn),
        .CFG_START(cfg_start), .CFG_ADDR(cfg_addr), .CFG_DW_COUNT(cfg_dw_count),
        .CFG_REQ_ID(cfg_req_id), .BUSY(busy), .DONE(done),
        .S00_AXIS_TVALID(s_tvalid), .S00_AXIS_TREADY(s_tready), .S00_AXIS_TDATA(s_tdata),
        .S00_AXIS_TKEEP(8'hFF), .S00_AXIS_TLAST(1'b0),
        .M00_AXIS_TVALID(m_tvalid), .M00_AXIS_TREADY(m_tready), .M00_AXIS_TDATA(m_tdata),
        .M00_AXIS_TKEEP(m_tkeep), .M00_AXIS_TLAST(m_tlast)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // TLP as a dword stream: H0 H1 H2 payload, zero-padded to whole beats.
    task automatic build_model(input logic [31:0] addr, input int count, input logic [15:0] rid);
        logic [31:0] dw[$];
        logic [31:0] tlp[$];
        logic [31:0] a;
        int rem, off, l, nb;
        bit padded;
        exp_data.delete();
        exp_kl.delete();
        foreach (in_beats[k]) begin
            dw.push_back(in_beats[k][31:0]);
            dw.push_back(in_beats[k][63:32]);
        end
        rem = count;
        off = 0;
        a = addr;
        while (rem > 0) begin
            l = (rem < MAXP) ? rem : MAXP;
            tlp.delete();
            tlp.push_back(32'h4000_0000 | 32'(l % 1024));
            tlp.push_back({rid, tag_m, ((l > 1) ? 4'hF : 4'h0), 4'hF});
            tlp.push_back({a[31:2], 2'b00});
            for (int i = 0; i < l; i++) tlp.push_back(dw[off + i]);
            padded = (tlp.size() % 2) != 0;
            if (padded) tlp.push_back(32'h0);
            nb = tlp.size() / 2;
            for (int j = 0; j < nb; j++) begin
                exp_data.push_back({tlp[2*j+1], tlp[2*j]});
                exp_kl.push_back({((padded && j == nb - 1) ? 8'h0F : 8'hFF), (j == nb - 1)});
            end
            rem -= l;
            off += l;
            a = a + 32'(4 * l);
            tag_m = tag_m + 8'd1;
        end
    endtask

    task automatic run_xfer(input logic [31:0] addr, input int count, input logic [15:0] rid,
                            input bit thr, input bit poke, input int exp_beats, input int exp_in);
        logic [63:0] got_d[$];
        logic [8:0]  got_kl[$];
        logic [63:0] prev_data;
        bit prev_stall, s_hs;
        int idx, done_iter, done_cnt;
        int need = (count + 1) / 2;
        in_beats.delete();
        for (int i = 0; i < need + 2; i++) in_beats.push_back({$urandom, $urandom});
        build_model(addr, count, rid);
        idx = 0; done_iter = -1; done_cnt = 0; prev_stall = 0; s_hs = 0;
        prev_data = 64'h0;
        s_tvalid = 1'b0;
        for (int iter = 0; iter < 4000; iter++) begin
            @(negedge aclk);
            cfg_start = (iter == 0) || (poke && iter == 3);
            if (iter == 0) begin
                cfg_addr = addr; cfg_dw_count = 24'(count); cfg_req_id = rid;
            end else if (poke && iter == 3) begin
                cfg_addr = addr ^ 32'h0F00_0000; cfg_dw_count = 24'd7; cfg_req_id = ~rid;
            end
            if (!(s_tvalid && !s_hs))
                s_tvalid = (idx < in_beats.size()) && (!thr || $urandom_range(0, 2) != 0);
            s_tdata  = (idx < in_beats.size()) ? in_beats[idx] : {$urandom, $urandom};
            m_tready = !thr || ($urandom_range(0, 1) == 1);
            #1;
            s_hs = s_tvalid && s_tready;
            if (s_hs) idx++;
            if (prev_stall) check("stable", {m_tvalid, m_tdata[62:0]}, {1'b1, prev_data[62:0]});
            if (m_tvalid && m_tready) begin
                got_d.push_back(m_tdata);
                got_kl.push_back({m_tkeep, m_tlast});
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data = m_tdata;
            if (iter == 1) check("busy_start", 64'(busy), 64'(count > 0));
            if (done) begin
                done_cnt++;
                if (done_iter < 0) begin
                    done_iter = iter;
                    check("busy_end", 64'(busy), 64'd0);
                end
            end
            if (done_iter >= 0 && iter >= done_iter + 3) break;
        end
        s_tvalid = 1'b0;
        cfg_start = 1'b0;
        if (done_iter < 0) check("timeout", 64'd1, 64'd0);
        check("beats_model", 64'(got_d.size()), 64'(exp_data.size()));
        if (exp_beats >= 0) check("beats_table", 64'(got_d.size()), 64'(exp_beats));
        check("in_consumed", 64'(idx), 64'(exp_in));
        check("done_count", 64'(done_cnt), 64'd1);
        if (!thr && done_iter >= 0) check("no_bubble", 64'(done_iter), 64'(exp_data.size() + 1));
        for (int j = 0; j < exp_data.size(); j++) begin
            if (j < got_d.size()) begin
                check("tdata", got_d[j], exp_data[j]);
                check("keep_last", 64'(got_kl[j]), 64'(exp_kl[j]));
            end
        end
        first_beat = (got_d.size() > 0) ? got_d[0] : 64'h0;
    endtask

    initial begin
        bit done_seen;
        int cnt;
        tbl[0] = '{32'h1000_0000, 1,  16'h0100, 1'b0, 1'b0, 2,  1};
        tbl[1] = '{32'h2000_0040, 70, 16'hBEEF, 1'b0, 1'b0, 41, 35};
        tbl[2] = '{32'h0000_0100, 3,  16'h1234, 1'b0, 1'b0, 3,  2};
        tbl[3] = '{32'h0000_0100, 3,  16'h1234, 1'b1, 1'b0, 3,  2};
        tbl[4] = '{32'h3000_0000, 0,  16'h5555, 1'b0, 1'b0, 0,  0};
        tbl[5] = '{32'h4000_0000, 10, 16'hA5A5, 1'b0, 1'b1, 7,  5};
        tbl[6] = '{32'h5000_0000, 64, 16'h0001, 1'b1, 1'b0, 36, 32};
        tbl[7] = '{32'h6000_0004, 33, 16'h7777, 1'b1, 1'b0, 20, 17};

        repeat (2) @(negedge aclk);
        #1;
        check("reset_data", m_tdata, 64'h0);
        check("reset_ctl", {52'h0, m_tvalid, m_tkeep, m_tlast, s_tready, busy, done}, 64'h0);
        @(negedge aclk);
        aresetn = 1'b1;

        run_xfer(32'h1000_0000, 4, 16'h0100, 1'b0, 1'b0, 4, 2);
        check("hdr_example", first_beat, 64'h0100_00FF_4000_0004);

        for (int v = 0; v < 8; v++)
            run_xfer(tbl[v].addr, tbl[v].count, tbl[v].rid, tbl[v].thr, tbl[v].poke,
                     tbl[v].beats, tbl[v].ins);

        for (int r = 0; r < 20; r++) begin
            cnt = $urandom_range(0, 80);
            run_xfer($urandom & 32'hFFFF_FFFC, cnt, 16'($urandom), bit'($urandom_range(0, 1)),
                     1'b0, -1, (cnt + 1) / 2);
        end

        // Reset in the middle of a TLP.
        @(negedge aclk);
        cfg_start = 1'b1; cfg_addr = 32'h7000_0000; cfg_dw_count = 24'd8; cfg_req_id = 16'h4242;
        s_tvalid = 1'b1; s_tdata = 64'h1111_2222_3333_4444; m_tready = 1'b1;
        @(negedge aclk);
        cfg_start = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b0;
        #1;
        check("midrst_data", m_tdata, 64'h0);
        check("midrst_ctl", {52'h0, m_tvalid, m_tkeep, m_tlast, s_tready, busy, done}, 64'h0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        s_tvalid = 1'b0;
        tag_m = 8'd0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            #1;
            done_seen = done_seen | done;
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        run_xfer(32'h7000_0100, 2, 16'h4242, 1'b0, 1'b0, 3, 1);
        check("tag_after_rst", 64'(first_beat[47:40]), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
